// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared control encodings for the multi-cycle RV32I controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multi-cycle RV32I control sequencer (Fetch/Decode/Execute/Mem/WB)
module main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp
);

  state_t state_q, state_d, cur;
  logic   pc_update, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    // Reset forces FETCH decoding so outputs are defined before the first edge.
    cur       = reset ? S_FETCH : state_q;
    state_d   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    IllegalOp = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        pc_update = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            IllegalOp = TRAP_ON_ILLEGAL;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_BRANCH;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    PCWrite = pc_update | (branch & Zero);
  end

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - directed self-checking bench for main_fsm
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

  int checks   = 0;
  int failures = 0;

  main_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .IllegalOp (IllegalOp)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,IllegalOp}
  logic [13:0] sig;
  assign sig = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, IllegalOp};

  function automatic logic [13:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic ir, input logic rw, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop, input logic ill);
    return {pcw, adr, mw, ir, rw, res, a, b, aop, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle, compare the output vector at the falling edge.
  task automatic cyc(input string tag, input logic rst, input logic mr, input logic z,
                     input logic [13:0] exp);
    reset    = rst;
    MemReady = mr;
    Zero     = z;
    @(negedge clk);
    check_eq(tag, {18'd0, sig}, {18'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [13:0] e_f1, e_f0, e_dec, e_ill, e_ma, e_mr, e_mwb, e_mw;
  logic [13:0] e_exr, e_exi, e_awb, e_beq1, e_beq0, e_jal;

  initial begin
    e_f1   = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    e_f0   = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    e_dec  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    e_ill  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 1);
    e_ma   = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    e_mr   = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    e_mwb  = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    e_mw   = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    e_exr  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    e_exi  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
    e_awb  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    e_beq1 = mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    e_beq0 = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    e_jal  = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);

    op = 7'b0000011;
    cyc("rst0", 1, 1, 0, e_f1);
    cyc("rst1", 1, 1, 0, e_f1);

    // lw, no stalls: 5 cycles
    cyc("lw_f",   0, 1, 0, e_f1);
    cyc("lw_d",   0, 1, 0, e_dec);
    cyc("lw_ma",  0, 1, 0, e_ma);
    cyc("lw_mr",  0, 1, 0, e_mr);
    cyc("lw_mwb", 0, 1, 0, e_mwb);

    // fetch stall, then sw with 3 stall cycles in MEMWRITE
    op = 7'b0100011;
    cyc("sw_fstall", 0, 0, 0, e_f0);
    cyc("sw_f",      0, 1, 0, e_f1);
    cyc("sw_d",      0, 1, 0, e_dec);
    cyc("sw_ma",     0, 1, 0, e_ma);
    cyc("sw_mw0",    0, 0, 0, e_mw);
    cyc("sw_mw1",    0, 0, 0, e_mw);
    cyc("sw_mw2",    0, 0, 0, e_mw);
    cyc("sw_mw3",    0, 1, 0, e_mw);

    // beq taken then not taken
    op = 7'b1100011;
    cyc("beq1_f",   0, 1, 1, e_f1);
    cyc("beq1_d",   0, 1, 1, e_dec);
    cyc("beq1_beq", 0, 1, 1, e_beq1);
    cyc("beq0_f",   0, 1, 0, e_f1);
    cyc("beq0_d",   0, 1, 0, e_dec);
    cyc("beq0_beq", 0, 1, 0, e_beq0);

    op = 7'b0110011;
    cyc("r_f",   0, 1, 0, e_f1);
    cyc("r_d",   0, 1, 0, e_dec);
    cyc("r_ex",  0, 1, 0, e_exr);
    cyc("r_awb", 0, 1, 0, e_awb);

    op = 7'b0010011;
    cyc("i_f",   0, 1, 0, e_f1);
    cyc("i_d",   0, 1, 0, e_dec);
    cyc("i_ex",  0, 1, 0, e_exi);
    cyc("i_awb", 0, 1, 0, e_awb);

    op = 7'b1101111;
    cyc("jal_f",   0, 1, 0, e_f1);
    cyc("jal_d",   0, 1, 0, e_dec);
    cyc("jal_jal", 0, 1, 0, e_jal);
    cyc("jal_awb", 0, 1, 0, e_awb);

    // illegal opcode: 2 cycles, IllegalOp pulses only in DECODE
    op = 7'b1111111;
    cyc("ill_f",  0, 1, 0, e_f1);
    cyc("ill_d",  0, 1, 0, e_ill);
    op = 7'b0000011;
    cyc("ill_f2", 0, 1, 0, e_f1);

    // lw stalled in MEMREAD, then reset abandons it
    cyc("rlw_d",   0, 1, 0, e_dec);
    cyc("rlw_ma",  0, 1, 0, e_ma);
    cyc("rlw_mr0", 0, 0, 0, e_mr);
    cyc("rlw_rst", 1, 0, 0, e_f0);
    cyc("rlw_f",   0, 0, 0, e_f0);
    cyc("rlw_f2",  0, 1, 0, e_f1);
    cyc("rlw_d2",  0, 1, 0, e_dec);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
